// File: rtl/mux_fifo_mc_if.sv
// Handshake bundle for the multi-channel unit packer: per-channel source beats in, one packed word stream out.
// Pure wiring, no latency of its own.
// Backpressure travels as src_ready/dst_ready inside the bundle; fifo_cnt exposes buffer occupancy.
interface mux_fifo_mc_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_UNIT       = 8,
    parameter int USER_INFO_WIDTH = 8,
    parameter int CHANNELS        = 4,
    parameter int DEPTH           = 8
);
    localparam int N   = DATA_WIDTH / DATA_UNIT;
    localparam int UW  = $clog2(N);
    localparam int CW  = $clog2(CHANNELS);
    localparam int FCW = $clog2(DEPTH + 1);

    logic [CHANNELS-1:0]                 src_valid;
    logic [CHANNELS-1:0]                 src_ready;
    logic [CHANNELS*DATA_WIDTH-1:0]      src_data;
    logic [CHANNELS*(UW+1)-1:0]          src_unit_num;
    logic [CHANNELS*UW-1:0]              src_offset;
    logic [CHANNELS-1:0]                 src_last;
    logic [CHANNELS*USER_INFO_WIDTH-1:0] src_user_info;

    logic                                dst_valid;
    logic                                dst_ready;
    logic [DATA_WIDTH-1:0]               dst_data;
    logic [N-1:0]                        dst_strb;
    logic [UW:0]                         dst_unit_num;
    logic                                dst_last;
    logic [CW-1:0]                       dst_chan;
    logic [USER_INFO_WIDTH-1:0]          dst_user_info;
    logic [FCW-1:0]                      fifo_cnt;

    // Packer side
    modport slave (
        input  src_valid, src_data, src_unit_num, src_offset, src_last, src_user_info,
        output src_ready,
        output dst_valid, dst_data, dst_strb, dst_unit_num, dst_last, dst_chan, dst_user_info,
        output fifo_cnt,
        input  dst_ready
    );

    // Producer/consumer side
    modport master (
        output src_valid, src_data, src_unit_num, src_offset, src_last, src_user_info,
        input  src_ready,
        input  dst_valid, dst_data, dst_strb, dst_unit_num, dst_last, dst_chan, dst_user_info,
        input  fifo_cnt,
        output dst_ready
    );
endinterface

// File: rtl/mux_fifo_mc.sv
// Round-robin packet arbiter + unit packer compacting partial beats into dense words, buffered in a DEPTH-entry FIFO.
// Latency: word written at an edge is visible on dst_* right after it; 1 arbitration bubble per packet.
// Backpressure: owner's src_ready drops while the FIFO is full (no bypass); dst_* hold while stalled. Optional: MUX_FIFO_MC_TIMEOUT_EN.
module mux_fifo_mc #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_UNIT       = 8,
    parameter int USER_INFO_WIDTH = 8,
    parameter int CHANNELS        = 4,
    parameter int DEPTH           = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    mux_fifo_mc_if.slave   bus
);
    localparam int N   = DATA_WIDTH / DATA_UNIT;
    localparam int UW  = $clog2(N);
    localparam int CW  = $clog2(CHANNELS);
    localparam int FCW = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);

    localparam logic [UW:0]    N_L     = (UW+1)'(N);
    localparam logic [FCW-1:0] DEPTH_L = FCW'(DEPTH);

    if (CHANNELS < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("mux_fifo_mc: unsupported parameter set");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_DRAIN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]      data;
        logic [N-1:0]               strb;
        logic [UW:0]                num;
        logic                       last;
        logic [CW-1:0]              chan;
        logic [USER_INFO_WIDTH-1:0] user;
    } entry_t;

    // Strobe with the low n bits set
    function automatic logic [N-1:0] strb_mask(input logic [UW:0] n);
        logic [N-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) begin
            if (k < int'(n)) m[k] = 1'b1;
        end
        return m;
    endfunction

    // Data mask covering the low n units
    function automatic logic [DATA_WIDTH-1:0] unit_mask(input logic [UW:0] n);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) begin
            if (k < int'(n)) m[k*DATA_UNIT +: DATA_UNIT] = '1;
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                     r_state;
    logic [CW-1:0]              r_owner;
    logic [CW-1:0]              r_rr_ptr;
    logic [UW-1:0]              r_fill;
    logic [DATA_WIDTH-1:0]      r_res;       // residual units, bits above r_fill kept at zero
    logic [USER_INFO_WIDTH-1:0] r_user;
    logic                       r_first_beat;

    entry_t                     r_mem [DEPTH];
    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_rd_ptr;
    logic [FCW-1:0]             r_cnt;

    // ------------------------------------------------------------------
    // Owner beat decode and packing datapath
    // ------------------------------------------------------------------
    logic                       w_full;
    logic                       w_empty;
    logic                       w_rd;
    logic                       w_o_valid;
    logic [DATA_WIDTH-1:0]      w_o_data;
    logic [UW:0]                w_o_num;
    logic [UW-1:0]              w_o_off;
    logic                       w_o_last;
    logic [USER_INFO_WIDTH-1:0] w_o_user;
    logic                       w_accept;
    logic [UW:0]                w_avail;
    logic [UW:0]                w_eff;
    logic [DATA_WIDTH-1:0]      w_src_sh;
    logic [2*DATA_WIDTH-1:0]    w_cat;
    logic [UW:0]                w_sum;
    logic                       w_wfull;
    logic [UW:0]                w_rem;
    logic                       w_to_fire;

    assign w_full    = (r_cnt == DEPTH_L);
    assign w_empty   = (r_cnt == '0);
    assign w_rd      = !w_empty && bus.dst_ready;

    assign w_o_valid = bus.src_valid[r_owner];
    assign w_o_data  = bus.src_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
    assign w_o_num   = bus.src_unit_num[r_owner*(UW+1) +: (UW+1)];
    assign w_o_off   = bus.src_offset[r_owner*UW +: UW];
    assign w_o_last  = bus.src_last[r_owner];
    assign w_o_user  = bus.src_user_info[r_owner*USER_INFO_WIDTH +: USER_INFO_WIDTH];

    assign w_accept  = (r_state == ST_LOCK) && w_o_valid && !w_full;

    // Units past the top of the beat are dropped rather than wrapped
    assign w_avail   = N_L - {1'b0, w_o_off};
    assign w_eff     = (w_o_num > w_avail) ? w_avail : w_o_num;
    assign w_src_sh  = (w_o_data >> (int'(w_o_off) * DATA_UNIT)) & unit_mask(w_eff);
    assign w_cat     = {{DATA_WIDTH{1'b0}}, r_res}
                     | ({{DATA_WIDTH{1'b0}}, w_src_sh} << (int'(r_fill) * DATA_UNIT));
    assign w_sum     = {1'b0, r_fill} + w_eff;
    assign w_wfull   = (w_sum >= N_L);
    assign w_rem     = w_wfull ? (w_sum - N_L) : w_sum;

    // Only the owner may see ready, and only while it holds the lock and there is room
    logic [CHANNELS-1:0] w_src_ready;
    always_comb begin
        w_src_ready = '0;
        if (r_state == ST_LOCK && !w_full) w_src_ready[r_owner] = 1'b1;
    end
    assign bus.src_ready = w_src_ready;

    // Round-robin pick: first valid channel after the previous owner
    logic [CW-1:0] w_pick;
    logic          w_pick_found;
    always_comb begin
        w_pick       = r_rr_ptr;
        w_pick_found = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            if (!w_pick_found && bus.src_valid[(int'(r_rr_ptr) + i) % CHANNELS]) begin
                w_pick       = CW'((int'(r_rr_ptr) + i) % CHANNELS);
                w_pick_found = 1'b1;
            end
        end
    end

`ifdef MUX_FIFO_MC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_to_cnt;
    logic          w_to_idle;

    assign w_to_idle = (r_state == ST_LOCK) && !w_accept && (r_fill != '0);
    assign w_to_fire = w_to_idle && (r_to_cnt == TO_LIM) && !w_full;

    // Count consecutive stalled cycles while a residual is parked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (flush || !w_to_idle || w_to_fire) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_LIM) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_to_fire = 1'b0;
`endif

    // FIFO write selection: full word, end-of-packet partial, drain partial, or stall flush
    logic   w_wr_en;
    entry_t w_wr_ent;
    always_comb begin
        w_wr_en       = 1'b0;
        w_wr_ent      = '0;
        w_wr_ent.chan = r_owner;
        w_wr_ent.user = r_first_beat ? w_o_user : r_user;
        if (w_accept) begin
            if (w_wfull) begin
                w_wr_en       = 1'b1;
                w_wr_ent.data = w_cat[DATA_WIDTH-1:0];
                w_wr_ent.strb = '1;
                w_wr_ent.num  = N_L;
                w_wr_ent.last = w_o_last && (w_rem == '0);
            end else if (w_o_last) begin
                // Covers the empty packet too: rem 0 gives a zero-strobe word
                w_wr_en       = 1'b1;
                w_wr_ent.data = w_cat[DATA_WIDTH-1:0];
                w_wr_ent.strb = strb_mask(w_rem);
                w_wr_ent.num  = w_rem;
                w_wr_ent.last = 1'b1;
            end
        end else if (r_state == ST_DRAIN && !w_full) begin
            w_wr_en       = 1'b1;
            w_wr_ent.data = r_res;
            w_wr_ent.strb = strb_mask({1'b0, r_fill});
            w_wr_ent.num  = {1'b0, r_fill};
            w_wr_ent.last = 1'b1;
            w_wr_ent.user = r_user;
        end else if (w_to_fire) begin
            w_wr_en       = 1'b1;
            w_wr_ent.data = r_res;
            w_wr_ent.strb = strb_mask({1'b0, r_fill});
            w_wr_ent.num  = {1'b0, r_fill};
            w_wr_ent.last = 1'b0;
            w_wr_ent.user = r_user;
        end
    end

    // Arbitration / packing FSM with residual and sideband registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_fill       <= '0;
            r_res        <= '0;
            r_user       <= '0;
            r_first_beat <= 1'b0;
        end else if (flush) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_fill       <= '0;
            r_res        <= '0;
            r_user       <= '0;
            r_first_beat <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        r_owner      <= w_pick;
                        r_first_beat <= 1'b1;
                        r_state      <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (w_accept) begin
                        r_first_beat <= 1'b0;
                        if (r_first_beat) r_user <= w_o_user;
                        r_fill <= w_rem[UW-1:0];
                        r_res  <= w_wfull ? w_cat[2*DATA_WIDTH-1:DATA_WIDTH] : w_cat[DATA_WIDTH-1:0];
                        if (w_o_last) begin
                            if (w_wfull && w_rem != '0) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_fill   <= '0;
                                r_res    <= '0;
                                r_rr_ptr <= r_owner;
                                r_state  <= ST_IDLE;
                            end
                        end
                    end else if (w_to_fire) begin
                        r_fill <= '0;
                        r_res  <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (!w_full) begin
                        r_fill   <= '0;
                        r_res    <= '0;
                        r_rr_ptr <= r_owner;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output FIFO: one write and one read per cycle, storage read directly as the registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_wr_ent;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    entry_t w_head;
    assign w_head            = r_mem[r_rd_ptr];
    assign bus.dst_valid     = !w_empty;
    assign bus.dst_data      = w_head.data;
    assign bus.dst_strb      = w_head.strb;
    assign bus.dst_unit_num  = w_head.num;
    assign bus.dst_last      = w_head.last;
    assign bus.dst_chan      = w_head.chan;
    assign bus.dst_user_info = w_head.user;
    assign bus.fifo_cnt      = r_cnt;
endmodule

// File: tb/tb_mux_fifo_mc.sv
// Directed bench for mux_fifo_mc: packing, arbitration order, drain, backpressure, flush, optional stall timeout.
// Inputs change 1 time unit after the rising edge; handshakes are sampled on the falling edge.
// Output words are captured into a queue and compared against hand-computed expectations.
module tb_mux_fifo_mc;
    localparam int DW  = 32;
    localparam int CH  = 4;
    localparam int DEP = 8;
    localparam int UW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    mux_fifo_mc_if #(.DATA_WIDTH(32), .DATA_UNIT(8), .USER_INFO_WIDTH(8), .CHANNELS(4), .DEPTH(8)) bus ();

    mux_fifo_mc #(
        .DATA_WIDTH(32), .DATA_UNIT(8), .USER_INFO_WIDTH(8),
        .CHANNELS(4), .DEPTH(8), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  num;
        logic        last;
        logic [1:0]  chan;
        logic [7:0]  user;
    } word_t;

    word_t obs_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture every accepted output word
    always @(negedge clk) begin
        if (rst_n && !flush && bus.dst_valid && bus.dst_ready)
            obs_q.push_back('{bus.dst_data, bus.dst_strb, bus.dst_unit_num, bus.dst_last,
                              bus.dst_chan, bus.dst_user_info});
    end

    task automatic send(input int ch, input logic [31:0] d, input int off, input int num,
                        input logic last, input logic [7:0] user);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.src_data[ch*DW +: DW]         = d;
        bus.src_offset[ch*UW +: UW]       = UW'(off);
        bus.src_unit_num[ch*(UW+1) +: 3]  = 3'(num);
        bus.src_last[ch]                  = last;
        bus.src_user_info[ch*8 +: 8]      = user;
        bus.src_valid[ch]                 = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.src_ready[ch];
            @(posedge clk);
            #1;
            n++;
        end
        bus.src_valid[ch] = 1'b0;
        if (!acc) chk("send_accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic [3:0] s,
                               input int num, input logic last, input int chan, input logic [7:0] user);
        int    n;
        word_t w;
        n = 0;
        while (obs_q.size() == 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, ".avail"}, 64'(obs_q.size() != 0), 64'd1);
        if (obs_q.size() != 0) begin
            w = obs_q.pop_front();
            chk({tag, ".data"}, 64'(w.data), 64'(d));
            chk({tag, ".strb"}, 64'(w.strb), 64'(s));
            chk({tag, ".num"},  64'(w.num),  64'(num));
            chk({tag, ".last"}, 64'(w.last), 64'(last));
            chk({tag, ".chan"}, 64'(w.chan), 64'(chan));
            chk({tag, ".user"}, 64'(w.user), 64'(user));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          exp_o[4];
        int          order[$];
        int          t_acc[$];
        int          cyc;
        logic [3:0]  acc_v;

        exp_o = '{1, 2, 3, 0};
        bus.src_valid     = '0;
        bus.src_data      = '0;
        bus.src_unit_num  = '0;
        bus.src_offset    = '0;
        bus.src_last      = '0;
        bus.src_user_info = '0;
        bus.dst_ready     = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.dst_valid", 64'(bus.dst_valid), 64'd0);
        chk("rst.fifo_cnt",  64'(bus.fifo_cnt),  64'd0);
        chk("rst.src_ready", 64'(bus.src_ready), 64'd0);
        chk("rst.dst_data",  64'(bus.dst_data),  64'd0);
        chk("rst.dst_strb",  64'(bus.dst_strb),  64'd0);
        chk("rst.dst_last",  64'(bus.dst_last),  64'd0);
        chk("rst.dst_chan",  64'(bus.dst_chan),  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle.src_ready", 64'(bus.src_ready), 64'd0);

        // All channels request single-beat packets: grant order from rr_ptr=0 is 1,2,3,0
        for (int i = 0; i < CH; i++) begin
            bus.src_data[i*DW +: DW]        = 32'h11111111 * (i + 1);
            bus.src_offset[i*UW +: UW]      = '0;
            bus.src_unit_num[i*3 +: 3]      = 3'd4;
            bus.src_last[i]                 = 1'b1;
            bus.src_user_info[i*8 +: 8]     = 8'(8'h10 + i);
        end
        bus.src_valid = 4'hF;
        cyc = 0;
        while (bus.src_valid != 0 && cyc < 100) begin
            @(negedge clk);
            acc_v = bus.src_valid & bus.src_ready;
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < CH; i++) begin
                if (acc_v[i]) begin
                    order.push_back(i);
                    t_acc.push_back(cyc);
                    bus.src_valid[i] = 1'b0;
                end
            end
        end
        bus.src_valid = '0;
        chk("rr.count", 64'(order.size()), 64'd4);
        for (int k = 0; k < order.size() && k < 4; k++) chk("rr.grant", 64'(order[k]), 64'(exp_o[k]));
        for (int k = 1; k < t_acc.size(); k++) chk("rr.gap", 64'(t_acc[k] - t_acc[k-1]), 64'd2);
        for (int k = 0; k < 4; k++)
            expect_word("rr.word", 32'h11111111 * (exp_o[k] + 1), 4'hF, 4, 1'b1, exp_o[k], 8'(8'h10 + exp_o[k]));

        // Partial beats: (off0,num3) then (off1,num2,last) -> full word then drained remainder
        send(0, 32'h44332211, 0, 3, 1'b0, 8'h01);
        send(0, 32'hDDCCBBAA, 1, 2, 1'b1, 8'h02);
        expect_word("t1.w0", 32'hBB332211, 4'hF, 4, 1'b0, 0, 8'h01);
        expect_word("t1.w1", 32'h000000CC, 4'h1, 1, 1'b1, 0, 8'h01);

        // Two full beats: exactly two words, no trailing empty word
        send(0, 32'h03020100, 0, 4, 1'b0, 8'h03);
        send(0, 32'h07060504, 0, 4, 1'b1, 8'h03);
        expect_word("t2.w0", 32'h03020100, 4'hF, 4, 1'b0, 0, 8'h03);
        expect_word("t2.w1", 32'h07060504, 4'hF, 4, 1'b1, 0, 8'h03);
        repeat (5) @(posedge clk);
        #1;
        chk("t2.no_extra", 64'(obs_q.size()), 64'd0);

        // Empty packet -> zero-strobe word
        send(0, 32'hFFFFFFFF, 0, 0, 1'b1, 8'h55);
        expect_word("zero", 32'h00000000, 4'h0, 0, 1'b1, 0, 8'h55);

        // offset 3, num 3: only one unit fits in the beat
        send(0, 32'hAB000000, 3, 3, 1'b1, 8'h56);
        expect_word("discard", 32'h000000AB, 4'h1, 1, 1'b1, 0, 8'h56);

        // ch1: fill 3 + num 3 on last beat -> full word, then DRAIN partial
        send(1, 32'h00A3A2A1, 0, 3, 1'b0, 8'h5A);
        send(1, 32'h00B3B2B1, 0, 3, 1'b1, 8'hFF);
        chk("t3.drain_rdy", 64'(bus.src_ready[1]), 64'd0);
        expect_word("t3.w0", 32'hB1A3A2A1, 4'hF, 4, 1'b0, 1, 8'h5A);
        expect_word("t3.w1", 32'h0000B3B2, 4'h3, 2, 1'b1, 1, 8'h5A);

        // Backpressure: fill the FIFO, check stall and hold, then release
        bus.dst_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) send(2, 32'hC0000000 + k, 0, 4, k == 9, 8'h22);
            end
            begin : bp_watch
                int n;
                n = 0;
                while (bus.fifo_cnt != 4'(DEP) && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("bp.cnt_full", 64'(bus.fifo_cnt), 64'(DEP));
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("bp.rdy_low", 64'(bus.src_ready[2]), 64'd0);
                    chk("bp.hold", 64'(bus.dst_data), 64'h00000000C0000000);
                end
                bus.dst_ready = 1'b1;
            end
        join
        for (int k = 0; k < 10; k++)
            expect_word("bp.word", 32'hC0000000 + k, 4'hF, 4, k == 9, 2, 8'h22);
        chk("bp.cnt_empty", 64'(bus.fifo_cnt), 64'd0);

        // Flush mid-packet
        bus.dst_ready = 1'b0;
        send(3, 32'h33333333, 0, 4, 1'b0, 8'h33);
        send(3, 32'h00004444, 0, 2, 1'b0, 8'h33);
        chk("fl.cnt_pre", 64'(bus.fifo_cnt), 64'd1);
        chk("fl.rdy_pre", 64'(bus.src_ready), 64'h8);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl.cnt", 64'(bus.fifo_cnt), 64'd0);
        chk("fl.vld", 64'(bus.dst_valid), 64'd0);
        chk("fl.rdy", 64'(bus.src_ready), 64'd0);
        bus.dst_ready = 1'b1;
        send(0, 32'h000000EE, 0, 1, 1'b1, 8'h44);
        expect_word("fl.post", 32'h000000EE, 4'h1, 1, 1'b1, 0, 8'h44);

`ifdef MUX_FIFO_MC_TIMEOUT_EN
        // Stalled residual is flushed after 4 idle cycles as a non-last partial word
        bus.dst_ready = 1'b0;
        send(1, 32'h00007788, 0, 2, 1'b0, 8'h66);
        repeat (3) @(posedge clk);
        #1;
        chk("to.early", 64'(bus.fifo_cnt), 64'd0);
        @(posedge clk);
        #1;
        chk("to.vld",  64'(bus.dst_valid), 64'd1);
        chk("to.strb", 64'(bus.dst_strb),  64'h3);
        chk("to.last", 64'(bus.dst_last),  64'd0);
        bus.dst_ready = 1'b1;
        expect_word("to.word", 32'h00007788, 4'h3, 2, 1'b0, 1, 8'h66);
        send(1, 32'h00000000, 0, 0, 1'b1, 8'h77);
        expect_word("to.end", 32'h00000000, 4'h0, 0, 1'b1, 1, 8'h66);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("end.empty", 64'(obs_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
